// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller: destuffed bit stream to bytes plus frame status.
// Optional statistics counters are enabled by defining HDLC_RX_STATS_EN.
module hdlc_rx_frame_ctrl #(
  parameter int MIN_BYTES = 4,
  parameter int LEN_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic             rx_valid,
  input  logic             det_disc,
  input  logic             det_flag,
  input  logic             det_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rx_overrun,
  output logic             frm_done,
  output logic [1:0]       frm_status,
`ifdef HDLC_RX_STATS_EN
  output logic [15:0]      stat_ok,
  output logic [15:0]      stat_bad,
  output logic [15:0]      stat_ovr,
`endif
  output logic [LEN_W-1:0] frm_len
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ABORT = 2'd1;
  localparam logic [1:0] ST_ALIGN = 2'd2;
  localparam logic [1:0] ST_SHORT = 2'd3;

  logic [1:0]       state;
  logic [6:0]       dl_q;
  logic [2:0]       dl_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       asm_q;
  logic [LEN_W-1:0] len_q;

  logic             is_err;
  logic             is_flag;
  logic             is_data;
  logic             in_frame;
  logic             shift_in;
  logic             exit_v;
  logic             exit_b;
  logic             byte_cmp;
  logic             stall;
  logic [2:0]       bc;
  logic [6:0]       asm_base;
  logic [6:0]       asm_nx;
  logic [LEN_W-1:0] len_base;
  logic [LEN_W-1:0] len_inc;
  logic [1:0]       end_status;

  always_comb begin
    is_err   = rx_valid && det_err;
    is_flag  = rx_valid && !det_err && det_flag;
    is_data  = rx_valid && !det_err && !det_flag && !det_disc;
    in_frame = (state == S_FRAME);
    shift_in = is_data && (state != S_HUNT);
    // the oldest bit leaves only once 7 bits are buffered
    exit_v   = shift_in && (dl_cnt == 3'd7);
    exit_b   = dl_q[6];
    bc       = in_frame ? bit_cnt : 3'd0;
    asm_base = in_frame ? asm_q : 7'd0;
    len_base = in_frame ? len_q : '0;
    byte_cmp = exit_v && (bc == 3'd7);
    stall    = out_valid && !out_ready;
    len_inc  = (&len_base) ? len_base
                           : len_base + 1'b1;
    asm_nx   = asm_base;
    for (int i = 0; i < 7; i++) begin
      if (bc == 3'(i)) asm_nx[i] = exit_b;
    end
    if (bit_cnt != 3'd0)
      end_status = ST_ALIGN;
    else if (len_q < LEN_W'(MIN_BYTES))
      end_status = ST_SHORT;
    else
      end_status = ST_OK;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HUNT;
      dl_q       <= '0;
      dl_cnt     <= '0;
      bit_cnt    <= '0;
      asm_q      <= '0;
      len_q      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      rx_overrun <= 1'b0;
      frm_done   <= 1'b0;
      frm_status <= '0;
      frm_len    <= '0;
    end else begin
      frm_done   <= 1'b0;
      rx_overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (shift_in) begin
        dl_q <= {dl_q[5:0], rx_bit};
        if (dl_cnt != 3'd7)
          dl_cnt <= dl_cnt + 3'd1;
      end

      if (exit_v) begin
        state   <= S_FRAME;
        asm_q   <= asm_nx;
        bit_cnt <= bc + 3'd1;
        len_q   <= byte_cmp ? len_inc : len_base;
      end

      // a completed byte is dropped if the previous one is still pending
      if (byte_cmp) begin
        if (stall) begin
          rx_overrun <= 1'b1;
        end else begin
          out_data  <= {exit_b, asm_base};
          out_valid <= 1'b1;
        end
      end

      if (is_err) begin
        state <= S_HUNT;
        if (in_frame) begin
          frm_done   <= 1'b1;
          frm_status <= ST_ABORT;
          frm_len    <= len_q;
        end
      end else if (is_flag) begin
        state  <= S_IDLE;
        dl_cnt <= '0;
        if (in_frame) begin
          frm_done   <= 1'b1;
          frm_status <= end_status;
          frm_len    <= len_q;
        end
      end
    end
  end

`ifdef HDLC_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ok  <= '0;
      stat_bad <= '0;
      stat_ovr <= '0;
    end else begin
      if (frm_done && (frm_status == ST_OK)
          && !(&stat_ok))
        stat_ok <= stat_ok + 16'd1;
      if (frm_done && (frm_status != ST_OK)
          && !(&stat_bad))
        stat_bad <= stat_bad + 16'd1;
      if (rx_overrun && !(&stat_ovr))
        stat_ovr <= stat_ovr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Bench for hdlc_rx_frame_ctrl: queue-based frame model
// with a per-cycle compare plus literal expectations.
module tb_hdlc_rx_frame_ctrl;

  localparam int LEN_W = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_bit = 1'b0;
  logic             rx_valid = 1'b0;
  logic             det_disc = 1'b0;
  logic             det_flag = 1'b0;
  logic             det_err = 1'b0;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             rx_overrun;
  logic             frm_done;
  logic [1:0]       frm_status;
  logic [LEN_W-1:0] frm_len;
`ifdef HDLC_RX_STATS_EN
  logic [15:0]      stat_ok;
  logic [15:0]      stat_bad;
  logic [15:0]      stat_ovr;
`endif

  hdlc_rx_frame_ctrl #(.MIN_BYTES(4), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .reset(reset),
    .rx_bit(rx_bit),
    .rx_valid(rx_valid),
    .det_disc(det_disc),
    .det_flag(det_flag),
    .det_err(det_err),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rx_overrun(rx_overrun),
    .frm_done(frm_done),
    .frm_status(frm_status),
`ifdef HDLC_RX_STATS_EN
    .stat_ok(stat_ok),
    .stat_bad(stat_bad),
    .stat_ovr(stat_ovr),
`endif
    .frm_len(frm_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  // model: state 0 hunt, 1 idle, 2 in frame
  int         m_state;
  bit         dq[$];
  int         m_bits;
  logic [7:0] m_asm;
  int         m_len;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;
  logic       m_done;
  logic [1:0] m_status;
  int         m_flen;

  int         ones;
  logic [7:0] got[$];
  int         done_cnt = 0;
  int         ovr_cnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; dq.delete();
    m_bits = 0; m_asm = 0; m_len = 0;
    m_valid = 0; m_data = 0; m_ovr = 0;
    m_done = 0; m_status = 0; m_flen = 0;
  endtask

  task automatic model_step();
    logic stall;
    bit   b;
    stall = m_valid && !out_ready;
    m_done = 0;
    m_ovr = 0;
    if (m_valid && out_ready) m_valid = 0;
    if (!rx_valid) return;
    if (det_err) begin
      if (m_state == 2) begin
        m_done = 1; m_status = 1; m_flen = m_len;
      end
      m_state = 0;
    end else if (det_flag) begin
      if (m_state == 2) begin
        m_done = 1;
        m_flen = m_len;
        if (m_bits != 0) m_status = 2;
        else if (m_len < 4) m_status = 3;
        else m_status = 0;
      end
      m_state = 1;
      dq.delete();
    end else if (!det_disc && m_state != 0) begin
      dq.push_back(rx_bit);
      if (dq.size() > 7) begin
        b = dq.pop_front();
        if (m_state == 1) begin
          m_state = 2; m_len = 0;
          m_bits = 0; m_asm = 0;
        end
        m_asm[m_bits] = b;
        m_bits++;
        if (m_bits == 8) begin
          if (stall) m_ovr = 1;
          else begin m_data = m_asm; m_valid = 1; end
          if (m_len < 4095) m_len++;
          m_bits = 0;
          m_asm = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("out_data", out_data, m_data);
      chk("rx_overrun", rx_overrun, m_ovr);
      chk("frm_done", frm_done, m_done);
      chk("frm_status", frm_status, m_status);
      chk("frm_len", frm_len, m_flen);
      if (frm_done) done_cnt++;
      if (rx_overrun) ovr_cnt++;
    end
  end

  always @(posedge clk) begin
    if (armed && !reset && out_valid && out_ready)
      got.push_back(out_data);
  end

  task automatic step(input logic v, input logic b,
                      input logic d, input logic f,
                      input logic e);
    rx_valid = v; rx_bit = b;
    det_disc = d; det_flag = f; det_err = e;
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic data_bit(input logic b);
    step(1, b, 0, 0, 0);
    if (b) ones++;
    else ones = 0;
    if (ones == 5) begin
      step(1, 0, 1, 0, 0);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] x);
    for (int i = 0; i < 8; i++) data_bit(x[i]);
  endtask

  task automatic flag_shared();
    repeat (6) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    ones = 0;
  endtask

  task automatic flag_full();
    step(1, 0, 0, 0, 0);
    flag_shared();
  endtask

  task automatic abort7();
    repeat (6) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    ones = 0;
  endtask

  task automatic do_reset();
    reset = 1; rx_valid = 0;
    det_disc = 0; det_flag = 0; det_err = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0;
  endtask

  task automatic chk_end(input string n,
                         input int st, input int len);
    chk({n, "_done"}, frm_done, 1);
    chk({n, "_status"}, frm_status, st);
    chk({n, "_len"}, frm_len, len);
  endtask

  int d0;
  int o0;

  initial begin
    ones = 0;
    model_reset();
    do_reset();
    armed = 1;
    idle(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_len", frm_len, 0);

    // 1: four plain bytes
    got.delete();
    flag_full();
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    flag_full();
    chk_end("t1", 0, 4);
    idle(3);
    chk("t1_cnt", got.size(), 4);
    if (got.size() == 4) begin
      chk("t1_b0", got[0], 8'h11);
      chk("t1_b1", got[1], 8'h22);
      chk("t1_b2", got[2], 8'h33);
      chk("t1_b3", got[3], 8'h44);
    end

    // 2: stuffed zeros removed
    got.delete();
    send_byte(8'h3E); send_byte(8'hFF);
    send_byte(8'h12); send_byte(8'h34);
    flag_full();
    chk_end("t2", 0, 4);
    idle(3);
    chk("t2_cnt", got.size(), 4);
    if (got.size() == 4) begin
      chk("t2_b0", got[0], 8'h3E);
      chk("t2_b1", got[1], 8'hFF);
    end

    // 3: abort, then data without leading flag
    got.delete();
    send_byte(8'h11); send_byte(8'h22);
    abort7();
    chk_end("t3", 1, 1);
    idle(2);
    got.delete();
    d0 = done_cnt;
    send_byte(8'h55); send_byte(8'h66);
    flag_full();
    idle(3);
    chk("t3_hunt_bytes", got.size(), 0);
    chk("t3_hunt_done", done_cnt, d0);

    // 4: misaligned, then short
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    data_bit(1); data_bit(0); data_bit(1);
    flag_full();
    chk_end("t4a", 2, 4);
    send_byte(8'h55); send_byte(8'h66);
    flag_full();
    chk_end("t4b", 3, 2);
    idle(3);

    // 5: consumer stalled across two bytes
    got.delete();
    o0 = ovr_cnt;
    out_ready = 0;
    send_byte(8'hA1); send_byte(8'hB2);
    flag_full();
    chk_end("t5", 3, 2);
    idle(3);
    chk("t5_ovr", ovr_cnt - o0, 1);
    chk("t5_hold_v", out_valid, 1);
    chk("t5_hold_d", out_data, 8'hA1);
    out_ready = 1;
    idle(3);
    chk("t5_cnt", got.size(), 1);
    if (got.size() == 1) chk("t5_b0", got[0], 8'hA1);

    // 6: back-to-back flags, then reset mid-frame
    got.delete();
    d0 = done_cnt;
    flag_full(); flag_shared(); flag_shared();
    idle(2);
    chk("t6_flag_done", done_cnt, d0);
    chk("t6_flag_bytes", got.size(), 0);
    send_byte(8'h77);
    data_bit(1); data_bit(0); data_bit(1);
    do_reset();
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 0);
    chk("t6_done", frm_done, 0);
    chk("t6_ovr", rx_overrun, 0);
    chk("t6_status", frm_status, 0);
    chk("t6_len", frm_len, 0);
    idle(3);
    chk("t6_no_done", done_cnt, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
